// File: rtl/pc_stack_unit_pkg.sv
// Shared constants and types for the program-counter / call-stack block.
package pc_stack_unit_pkg;

  localparam int AW          = 8;
  localparam int DW          = 16;
  localparam int DAW         = 8;
  localparam int STACK_BASE  = 32'h0000_00FF;
  localparam int STACK_DEPTH = 16;

  localparam int ERR_OVF = 1;
  localparam int ERR_UNF = 0;

  typedef enum logic [2:0] {
    PC_HOLD      = 3'd0,
    PC_LOAD_IMEM = 3'd1,
    PC_LOAD_DMEM = 3'd2,
    PC_SAVE_CNT  = 3'd3,
    PC_GET_PC    = 3'd4,
    PC_INC       = 3'd5
  } pc_act_e;

endpackage

// File: rtl/pc_stack_unit_sp_ctrl.sv
// Stack pointer, depth tracking, error flags and the data-memory stack port.
// Full/empty guarding and sticky errors exist only when STACK_GUARD_EN is defined.
module pc_stack_unit_sp_ctrl
  import pc_stack_unit_pkg::*;
#(
  parameter int P_AW          = AW,
  parameter int P_DW          = DW,
  parameter int P_DAW         = DAW,
  parameter int P_STACK_BASE  = STACK_BASE,
  parameter int P_STACK_DEPTH = STACK_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [P_AW-1:0]  i_pc,
  output logic [P_DAW-1:0] o_stack_addr,
  output logic             o_stack_we,
  output logic [P_DW-1:0]  o_stack_wdata,
  output logic             o_stack_full,
  output logic             o_stack_empty,
  output logic [1:0]       o_stack_err,
  output logic             o_pop_bad
);

  localparam int DEPTH_W = $clog2(P_STACK_DEPTH + 1);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(P_STACK_DEPTH);
  localparam logic [P_DAW-1:0]   SP_RST    = P_DAW'(P_STACK_BASE);

  logic [P_DAW-1:0]   r_sp;
  logic [DEPTH_W-1:0] r_depth;
  logic w_push_only, w_pop_only, w_full, w_empty, w_do_push, w_do_pop;

  // Simultaneous PUSH and POP cancel each other.
  assign w_push_only = i_push & ~i_pop;
  assign w_pop_only  = i_pop & ~i_push;
  assign w_full      = (r_depth == DEPTH_MAX);
  assign w_empty     = (r_depth == {DEPTH_W{1'b0}});

`ifdef STACK_GUARD_EN
  logic [1:0] r_err;
  logic       r_pop_bad;

  assign w_do_push = w_push_only & ~w_full;
  assign w_do_pop  = w_pop_only & ~w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err     <= 2'b00;
      r_pop_bad <= 1'b0;
    end else begin
      r_err[ERR_OVF] <= r_err[ERR_OVF] | (w_push_only & w_full);
      r_err[ERR_UNF] <= r_err[ERR_UNF] | (w_pop_only & w_empty);
      r_pop_bad      <= w_pop_only & w_empty;
    end
  end

  assign o_stack_err = r_err;
  assign o_pop_bad   = r_pop_bad;
`else
  assign w_do_push   = w_push_only;
  assign w_do_pop    = w_pop_only;
  assign o_stack_err = 2'b00;
  assign o_pop_bad   = 1'b0;
`endif

  // Depth saturates so full/empty still report when pushes/pops are unguarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp    <= SP_RST;
      r_depth <= {DEPTH_W{1'b0}};
    end else if (w_do_push) begin
      r_sp <= r_sp - P_DAW'(1);
      if (!w_full) r_depth <= r_depth + DEPTH_W'(1);
    end else if (w_do_pop) begin
      r_sp <= r_sp + P_DAW'(1);
      if (!w_empty) r_depth <= r_depth - DEPTH_W'(1);
    end
  end

  always_comb begin
    o_stack_addr = r_sp;
    if (w_do_pop) begin
      o_stack_addr = r_sp + P_DAW'(1);
    end else begin
      o_stack_addr = r_sp;
    end
  end

  assign o_stack_we    = w_do_push;
  assign o_stack_wdata = {{(P_DW-P_AW){1'b0}}, i_pc};
  assign o_stack_full  = w_full;
  assign o_stack_empty = w_empty;

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter, fetch counter and call-stack port fed by the control unit.
// Optional macro STACK_GUARD_EN enables full/empty guarding and sticky stack errors.
module pc_stack_unit
  import pc_stack_unit_pkg::*;
#(
  parameter int P_AW          = AW,
  parameter int P_DW          = DW,
  parameter int P_DAW         = DAW,
  parameter int P_STACK_BASE  = STACK_BASE,
  parameter int P_STACK_DEPTH = STACK_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_increm_pc,
  input  logic             i_get_address_from_pc,
  input  logic             i_pc_save_address_from_counter,
  input  logic             i_pc_save_address_from_instr_mem,
  input  logic             i_pc_save_address_from_data_mem,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [P_AW-1:0]  i_branch_addr,
  input  logic [P_DW-1:0]  i_mem_rdata,
  output logic [P_AW-1:0]  o_instr_addr,
  output logic [P_AW-1:0]  o_pc_out,
  output logic [P_DAW-1:0] o_stack_addr,
  output logic             o_stack_we,
  output logic [P_DW-1:0]  o_stack_wdata,
  output logic             o_stack_full,
  output logic             o_stack_empty,
  output logic [1:0]       o_stack_err
);

  logic [P_AW-1:0] r_cnt;
  logic [P_AW-1:0] r_pc;
  logic            w_pop_bad;
  logic            w_unused_rdata;
  pc_act_e         w_act;

  assign w_unused_rdata = ^i_mem_rdata[P_DW-1:P_AW];

  // One PC/counter action per cycle; a return load right after a rejected pop is dropped.
  always_comb begin
    w_act = PC_HOLD;
    if (i_pc_save_address_from_instr_mem) begin
      w_act = PC_LOAD_IMEM;
    end else if (i_pc_save_address_from_data_mem) begin
      if (w_pop_bad) w_act = PC_HOLD;
      else           w_act = PC_LOAD_DMEM;
    end else if (i_pc_save_address_from_counter) begin
      w_act = PC_SAVE_CNT;
    end else if (i_get_address_from_pc) begin
      w_act = PC_GET_PC;
    end else if (i_increm_pc) begin
      w_act = PC_INC;
    end else begin
      w_act = PC_HOLD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= {P_AW{1'b0}};
      r_pc  <= {P_AW{1'b0}};
    end else begin
      case (w_act)
        PC_LOAD_IMEM: begin
          r_cnt <= i_branch_addr;
          r_pc  <= i_branch_addr;
        end
        PC_LOAD_DMEM: begin
          r_cnt <= i_mem_rdata[P_AW-1:0];
          r_pc  <= i_mem_rdata[P_AW-1:0];
        end
        PC_SAVE_CNT: r_pc  <= r_cnt;
        PC_GET_PC:   r_cnt <= r_pc;
        PC_INC:      r_cnt <= r_cnt + P_AW'(1);
        default: begin
          r_cnt <= r_cnt;
          r_pc  <= r_pc;
        end
      endcase
    end
  end

  assign o_instr_addr = r_cnt;
  assign o_pc_out     = r_pc;

  pc_stack_unit_sp_ctrl #(
    .P_AW          (P_AW),
    .P_DW          (P_DW),
    .P_DAW         (P_DAW),
    .P_STACK_BASE  (P_STACK_BASE),
    .P_STACK_DEPTH (P_STACK_DEPTH)
  ) u_sp_ctrl (
    .clk           (clk),
    .rst           (rst),
    .i_push        (i_push),
    .i_pop         (i_pop),
    .i_pc          (r_pc),
    .o_stack_addr  (o_stack_addr),
    .o_stack_we    (o_stack_we),
    .o_stack_wdata (o_stack_wdata),
    .o_stack_full  (o_stack_full),
    .o_stack_empty (o_stack_empty),
    .o_stack_err   (o_stack_err),
    .o_pop_bad     (w_pop_bad)
  );

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed and random checks of pc_stack_unit against a behavioural PC/stack/memory model.
module tb_pc_stack_unit;

`ifdef STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int DEPTH = 16;

  localparam logic [6:0] S_NONE = 7'b0000000;
  localparam logic [6:0] S_IMEM = 7'b1000000;
  localparam logic [6:0] S_DMEM = 7'b0100000;
  localparam logic [6:0] S_SAVE = 7'b0010000;
  localparam logic [6:0] S_GET  = 7'b0001000;
  localparam logic [6:0] S_INC  = 7'b0000100;
  localparam logic [6:0] S_PUSH = 7'b0000010;
  localparam logic [6:0] S_POP  = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_inc, i_get, i_save, i_imem, i_dmem, i_push, i_pop;
  logic [7:0]  i_branch_addr;
  logic [15:0] i_mem_rdata;
  logic [7:0]  o_instr_addr, o_pc_out, o_stack_addr;
  logic        o_stack_we, o_stack_full, o_stack_empty;
  logic [15:0] o_stack_wdata;
  logic [1:0]  o_stack_err;

  int tests = 0;
  int fails = 0;

  int m_cnt, m_pc, m_sp, m_depth, m_err;
  bit m_pop_bad;
  logic [15:0] mem [256];
  logic [15:0] idle_rdata, next_rdata;
  bit e_pushok, e_popok, e_ovf, e_unf;
  int e_addr;

  always #5 clk = ~clk;

  pc_stack_unit dut (
    .clk                              (clk),
    .rst                              (rst),
    .i_increm_pc                      (i_inc),
    .i_get_address_from_pc            (i_get),
    .i_pc_save_address_from_counter   (i_save),
    .i_pc_save_address_from_instr_mem (i_imem),
    .i_pc_save_address_from_data_mem  (i_dmem),
    .i_push                           (i_push),
    .i_pop                            (i_pop),
    .i_branch_addr                    (i_branch_addr),
    .i_mem_rdata                      (i_mem_rdata),
    .o_instr_addr                     (o_instr_addr),
    .o_pc_out                         (o_pc_out),
    .o_stack_addr                     (o_stack_addr),
    .o_stack_we                       (o_stack_we),
    .o_stack_wdata                    (o_stack_wdata),
    .o_stack_full                     (o_stack_full),
    .o_stack_empty                    (o_stack_empty),
    .o_stack_err                      (o_stack_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_cnt = 0; m_pc = 0; m_sp = 255; m_depth = 0; m_err = 0; m_pop_bad = 1'b0;
    next_rdata = idle_rdata;
  endtask

  task automatic check_all();
    chk("instr_addr",  o_instr_addr,  m_cnt);
    chk("pc_out",      o_pc_out,      m_pc);
    chk("stack_addr",  o_stack_addr,  e_addr);
    chk("stack_we",    o_stack_we,    e_pushok);
    chk("stack_wdata", o_stack_wdata, m_pc);
    chk("stack_full",  o_stack_full,  m_depth == DEPTH);
    chk("stack_empty", o_stack_empty, m_depth == 0);
    chk("stack_err",   o_stack_err,   m_err);
  endtask

  // Apply strobes on the falling edge, predict the stack port, then check everything.
  task automatic drive(input logic [6:0] s, input int ba);
    bit po, qo;
    @(negedge clk);
    {i_imem, i_dmem, i_save, i_get, i_inc, i_push, i_pop} = s;
    i_branch_addr = 8'(ba);
    i_mem_rdata   = next_rdata;
    #1;
    po = i_push && !i_pop;
    qo = i_pop && !i_push;
    e_pushok = po && (!GUARD || m_depth < DEPTH);
    e_popok  = qo && (!GUARD || m_depth > 0);
    e_ovf    = GUARD && po && (m_depth == DEPTH);
    e_unf    = GUARD && qo && (m_depth == 0);
    e_addr   = e_popok ? (m_sp + 1) % 256 : m_sp;
    check_all();
  endtask

  // Advance the reference model across one rising edge.
  task automatic tick();
    bit old_pop_bad;
    @(posedge clk);
    old_pop_bad = m_pop_bad;
    next_rdata  = idle_rdata;
    if (e_pushok) begin
      mem[m_sp] = 16'(m_pc);
      m_sp = (m_sp + 255) % 256;
      if (m_depth < DEPTH) m_depth++;
    end else if (e_popok) begin
      next_rdata = mem[(m_sp + 1) % 256];
      m_sp = (m_sp + 1) % 256;
      if (m_depth > 0) m_depth--;
    end
    if (e_ovf) m_err = m_err | 2;
    if (e_unf) m_err = m_err | 1;
    m_pop_bad = e_unf;
    if (i_imem) begin
      m_cnt = i_branch_addr; m_pc = i_branch_addr;
    end else if (i_dmem) begin
      if (!old_pop_bad) begin
        m_cnt = i_mem_rdata[7:0]; m_pc = i_mem_rdata[7:0];
      end
    end else if (i_save) m_pc = m_cnt;
    else if (i_get) m_cnt = m_pc;
    else if (i_inc) m_cnt = (m_cnt + 1) % 256;
  endtask

  task automatic do_reset();
    @(negedge clk);
    {i_imem, i_dmem, i_save, i_get, i_inc, i_push, i_pop} = S_NONE;
    rst = 1'b1;
    #1;
    m_reset();
    e_pushok = 1'b0; e_popok = 1'b0; e_ovf = 1'b0; e_unf = 1'b0; e_addr = 255;
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    {i_imem, i_dmem, i_save, i_get, i_inc, i_push, i_pop} = S_NONE;
    i_branch_addr = 8'h00;
    idle_rdata = 16'h0000;
    i_mem_rdata = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    m_reset();
    do_reset();

    // Fetch sequence
    for (int i = 1; i <= 3; i++) begin
      drive(S_INC, 0); tick();
      drive(S_SAVE, 0); chk("fetch_addr", o_instr_addr, i); tick();
    end
    drive(S_NONE, 0); chk("fetch_pc", o_pc_out, 32'd3); tick();

    // Asynchronous reset in the middle of counting
    drive(S_INC, 0); tick();
    drive(S_INC, 0); tick();
    drive(S_INC, 0); chk("pre_rst_cnt", o_instr_addr, 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("rst_instr_addr", o_instr_addr, 32'h00);
    chk("rst_pc_out",     o_pc_out,     32'h00);
    chk("rst_stack_addr", o_stack_addr, 32'hFF);
    chk("rst_stack_we",   o_stack_we,   32'd0);
    chk("rst_wdata",      o_stack_wdata, 32'h0);
    chk("rst_full",       o_stack_full,  32'd0);
    chk("rst_empty",      o_stack_empty, 32'd1);
    chk("rst_err",        o_stack_err,   32'd0);
    {i_imem, i_dmem, i_save, i_get, i_inc, i_push, i_pop} = S_NONE;
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // JMP/RET through the stack
    for (int i = 0; i < 4; i++) begin drive(S_INC, 0); tick(); end
    drive(S_SAVE, 0); tick();
    drive(S_PUSH | S_IMEM, 8'h20);
    chk("jmp_addr", o_stack_addr, 32'hFF);
    chk("jmp_we", o_stack_we, 32'd1);
    chk("jmp_wdata", o_stack_wdata, 32'h0004);
    tick();
    drive(S_POP, 0);
    chk("jmp_pc", o_pc_out, 32'h20);
    chk("ret_addr", o_stack_addr, 32'hFF);
    tick();
    drive(S_DMEM, 0); tick();
    drive(S_NONE, 0);
    chk("ret_pc", o_pc_out, 32'h04);
    chk("ret_empty", o_stack_empty, 32'd1);
    tick();

    // Priority and counter wrap
    drive(S_IMEM | S_INC, 8'h10); tick();
    drive(S_NONE, 0); chk("prio_cnt", o_instr_addr, 32'h10); tick();
    drive(S_IMEM, 8'hFF); tick();
    drive(S_INC, 0); tick();
    drive(S_NONE, 0); chk("wrap_cnt", o_instr_addr, 32'h00); tick();

    // Overflow
    for (int i = 0; i < 16; i++) begin drive(S_PUSH, 0); tick(); end
    drive(S_PUSH, 0);
    chk("ovf_we", o_stack_we, GUARD ? 32'd0 : 32'd1);
    chk("ovf_addr", o_stack_addr, 32'hEF);
    tick();
    drive(S_NONE, 0);
    chk("ovf_err", o_stack_err, GUARD ? 32'd2 : 32'd0);
    chk("ovf_sp", o_stack_addr, GUARD ? 32'hEF : 32'hEE);
    chk("ovf_full", o_stack_full, 32'd1);
    tick();

    // Underflow followed by a return load
    mem[0] = 16'h0033;
    idle_rdata = 16'h0033;
    do_reset();
    drive(S_POP, 0); tick();
    drive(S_DMEM, 0); tick();
    drive(S_NONE, 0);
    chk("unf_err", o_stack_err, GUARD ? 32'd1 : 32'd0);
    chk("unf_pc", o_pc_out, GUARD ? 32'h00 : 32'h33);
    chk("unf_sp", o_stack_addr, GUARD ? 32'hFF : 32'h00);
    tick();

    // Random traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic [6:0] s;
      for (int b = 0; b < 7; b++) s[b] = ($urandom_range(0, 3) == 0);
      idle_rdata = 16'($urandom);
      drive(s, $urandom_range(0, 255));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
